// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller.
// Holds the opcode and Function field constants, the ALU_Control encodings,
// the mux select encodings and the controller state enumeration.
package multicycle_controller_pkg;

    // instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // instruction[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTEXEC   = 4'd6,
        S_RTWB     = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps the R-type Function field to ALU_Control.
// Ports:
//   func     in  6  instruction[5:0]
//   alu_ctrl out 3  ALU operation; unknown codes fall back to add
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (func)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_MUL:  alu_ctrl = ALU_MUL;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle MIPS-style datapath.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | read instruction, PC += 4 when memory returns data
//   DECODE   | register read, branch target computed into ALUOut
//   MEMADR   | lw/sw effective address = A + SignImm
//   MEMRD    | lw data read, wait for Mem_Ready
//   MEMWB    | lw data written to rt
//   MEMWR    | sw data written, wait for Mem_Ready
//   RTEXEC   | R-type ALU operation from Function
//   RTWB     | R-type result written to rd
//   BEQ      | compare A - B, branch to ALUOut on zero
//   ADDIEXEC | A + SignImm
//   ADDIWB   | addi result written to rt
//   JUMP     | PC <= jump target
//
// Ports:
//   CLK, RST (async, active low)
//   OP_Code[5:0], Function[5:0], Zero_Flag, Mem_Ready   inputs
//   IRWrite, IorD, MemWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], PCEn, ALU_Control[2:0], Busy  outputs
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OP_Code,
    input  logic [5:0] Function,
    input  logic       Zero_Flag,
    input  logic       Mem_Ready,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] ALU_Control,
    output logic       Busy
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] rt_alu_ctrl;

    logic       ir_write_c;
    logic       pc_write_c;
    logic       branch_c;
    logic       mem_write_c;
    logic       reg_write_c;

    alu_decoder u_alu_decoder (
        .func     (Function),
        .alu_ctrl (rt_alu_ctrl)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        branch_c    = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = PCSRC_ALU;
        ALU_Control = 3'b000;

        case (state_q)
            S_FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                ALU_Control = ALU_ADD;
                PCSrc       = PCSRC_ALU;
                // IR load and PC increment only happen once the read lands
                if (Mem_Ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB     = SRCB_IMM_SH;
                ALU_Control = ALU_ADD;
                case (OP_Code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALU_Control = ALU_ADD;
                state_d     = (OP_Code == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (Mem_Ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegDst      = 1'b0;
                MemtoReg    = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_c = 1'b1;
                if (Mem_Ready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALU_Control = rt_alu_ctrl;
                state_d     = S_RTWB;
            end
            S_RTWB: begin
                RegDst      = 1'b1;
                MemtoReg    = 1'b0;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALU_Control = ALU_SUB;
                PCSrc       = PCSRC_ALUOUT;
                branch_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALU_Control = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegDst      = 1'b0;
                MemtoReg    = 1'b0;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                pc_write_c = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The state register already sits in FETCH during reset, but FETCH's
    // write enables follow Mem_Ready, so they are qualified by RST too.
    assign IRWrite  = ir_write_c & RST;
    assign MemWrite = mem_write_c & RST;
    assign RegWrite = reg_write_c & RST;
    assign PCEn     = (pc_write_c | (branch_c & Zero_Flag)) & RST;
    assign Busy     = (state_q != S_FETCH);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       CLK;
    logic       RST;
    logic [5:0] OP_Code;
    logic [5:0] Function;
    logic       Zero_Flag;
    logic       Mem_Ready;
    logic       IRWrite, IorD, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [2:0] ALU_Control;
    logic       Busy;

    int n_tests;
    int n_fail;

    multicycle_controller dut (
        .CLK         (CLK),
        .RST         (RST),
        .OP_Code     (OP_Code),
        .Function    (Function),
        .Zero_Flag   (Zero_Flag),
        .Mem_Ready   (Mem_Ready),
        .IRWrite     (IRWrite),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSrc       (PCSrc),
        .PCEn        (PCEn),
        .ALU_Control (ALU_Control),
        .Busy        (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bundle order: IRWrite IorD MemWrite MemtoReg RegDst RegWrite ALUSrcA
    //               ALUSrcB[1:0] PCSrc[1:0] PCEn ALU_Control[2:0] Busy
    function automatic logic [15:0] mk(input logic irw, input logic iord, input logic mw,
                                       input logic m2r, input logic rdst, input logic rw,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] pcs, input logic pcen,
                                       input logic [2:0] aluc, input logic busy);
        return {irw, iord, mw, m2r, rdst, rw, srca, srcb, pcs, pcen, aluc, busy};
    endfunction

    function automatic logic [15:0] outs();
        return {IRWrite, IorD, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, PCEn, ALU_Control, Busy};
    endfunction

    // Checks the current cycle's state and outputs, then advances one clock.
    task automatic cyc(input string tag, input state_e exp_state, input logic [15:0] exp_outs);
        #1;
        chk({tag, ".state"}, 32'(dut.state_q), 32'(exp_state));
        chk({tag, ".outs"},  32'(outs()), 32'(exp_outs));
        @(posedge CLK);
        #2;
    endtask

    logic [15:0] o_fetch1, o_fetch0, o_decode, o_memadr, o_memrd, o_memwb, o_memwr;
    logic [15:0] o_rtwb, o_addiexec, o_addiwb, o_jump;

    logic [5:0] fn_tab  [6];
    logic [2:0] alu_tab [6];

    initial begin
        o_fetch1   = mk(1,0,0,0,0,0,0,2'b01,2'b00,1,3'b010,0);
        o_fetch0   = mk(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
        o_decode   = mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
        o_memadr   = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,1);
        o_memrd    = mk(0,1,0,0,0,0,0,2'b00,2'b00,0,3'b000,1);
        o_memwb    = mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b000,1);
        o_memwr    = mk(0,1,1,0,0,0,0,2'b00,2'b00,0,3'b000,1);
        o_rtwb     = mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b000,1);
        o_addiexec = mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,1);
        o_addiwb   = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b000,1);
        o_jump     = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b000,1);

        fn_tab[0] = 6'b100010; alu_tab[0] = 3'b100;
        fn_tab[1] = 6'b011100; alu_tab[1] = 3'b101;
        fn_tab[2] = 6'b100100; alu_tab[2] = 3'b000;
        fn_tab[3] = 6'b100101; alu_tab[3] = 3'b001;
        fn_tab[4] = 6'b101010; alu_tab[4] = 3'b110;
        fn_tab[5] = 6'b111111; alu_tab[5] = 3'b010;

        n_tests   = 0;
        n_fail    = 0;
        RST       = 1'b0;
        OP_Code   = 6'b100011;
        Function  = 6'b000000;
        Zero_Flag = 1'b0;
        Mem_Ready = 1'b1;

        // Reset: enables low even with Mem_Ready high
        #3;
        chk("rst.state", 32'(dut.state_q), 32'(S_FETCH));
        chk("rst.irwrite", 32'(IRWrite), 32'd0);
        chk("rst.pcen", 32'(PCEn), 32'd0);
        chk("rst.busy", 32'(Busy), 32'd0);
        chk("rst.wr", 32'({MemWrite, RegWrite}), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // lw, no wait states
        OP_Code = 6'b100011;
        cyc("lw.c1", S_FETCH,  o_fetch1);
        cyc("lw.c2", S_DECODE, o_decode);
        cyc("lw.c3", S_MEMADR, o_memadr);
        cyc("lw.c4", S_MEMRD,  o_memrd);
        cyc("lw.c5", S_MEMWB,  o_memwb);

        // sw with three wait cycles in MEMWR
        OP_Code = 6'b101011;
        cyc("sw.c1", S_FETCH,  o_fetch1);
        cyc("sw.c2", S_DECODE, o_decode);
        cyc("sw.c3", S_MEMADR, o_memadr);
        Mem_Ready = 1'b0;
        cyc("sw.w1", S_MEMWR, o_memwr);
        cyc("sw.w2", S_MEMWR, o_memwr);
        cyc("sw.w3", S_MEMWR, o_memwr);
        Mem_Ready = 1'b1;
        cyc("sw.w4", S_MEMWR, o_memwr);

        // R-type across Function codes, including an unknown one
        OP_Code = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            Function = fn_tab[i];
            cyc("rt.c1", S_FETCH,  o_fetch1);
            cyc("rt.c2", S_DECODE, o_decode);
            cyc($sformatf("rt.exec.%0d", i), S_RTEXEC,
                mk(0,0,0,0,0,0,1,2'b00,2'b00,0,alu_tab[i],1));
            cyc("rt.wb", S_RTWB, o_rtwb);
        end

        // beq taken then not taken
        OP_Code = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            Zero_Flag = 1'b0;
            cyc("beq.c1", S_FETCH,  o_fetch1);
            cyc("beq.c2", S_DECODE, o_decode);
            Zero_Flag = z[0];
            cyc($sformatf("beq.z%0d", z), S_BEQ,
                mk(0,0,0,0,0,0,1,2'b00,2'b01,z[0],3'b100,1));
        end
        Zero_Flag = 1'b0;

        // addi
        OP_Code = 6'b001000;
        cyc("addi.c1", S_FETCH,    o_fetch1);
        cyc("addi.c2", S_DECODE,   o_decode);
        cyc("addi.c3", S_ADDIEXEC, o_addiexec);
        cyc("addi.c4", S_ADDIWB,   o_addiwb);

        // j
        OP_Code = 6'b000010;
        cyc("j.c1", S_FETCH,  o_fetch1);
        cyc("j.c2", S_DECODE, o_decode);
        cyc("j.c3", S_JUMP,   o_jump);

        // illegal opcode returns to FETCH without writes
        OP_Code = 6'b111111;
        cyc("ill.c1", S_FETCH,  o_fetch1);
        cyc("ill.c2", S_DECODE, o_decode);
        Mem_Ready = 1'b0;
        cyc("ill.c3", S_FETCH,  o_fetch0);

        // FETCH holds while memory not ready
        cyc("fwait.1", S_FETCH, o_fetch0);
        Mem_Ready = 1'b1;

        // reset during MEMRD
        OP_Code = 6'b100011;
        cyc("rlw.c1", S_FETCH,  o_fetch1);
        cyc("rlw.c2", S_DECODE, o_decode);
        cyc("rlw.c3", S_MEMADR, o_memadr);
        Mem_Ready = 1'b0;
        cyc("rlw.c4", S_MEMRD,  o_memrd);
        #1;
        chk("rlw.pre", 32'(dut.state_q), 32'(S_MEMRD));
        Mem_Ready = 1'b1;
        RST = 1'b0;
        #1;
        chk("rlw.rst.state", 32'(dut.state_q), 32'(S_FETCH));
        chk("rlw.rst.en", 32'({IRWrite, MemWrite, RegWrite, PCEn, Busy}), 32'd0);
        @(posedge CLK);
        #2;
        chk("rlw.rst.hold", 32'(dut.state_q), 32'(S_FETCH));
        chk("rlw.rst.en2", 32'({IRWrite, MemWrite, RegWrite, PCEn, Busy}), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // resumes normally
        OP_Code = 6'b001000;
        cyc("res.c1", S_FETCH,    o_fetch1);
        cyc("res.c2", S_DECODE,   o_decode);
        cyc("res.c3", S_ADDIEXEC, o_addiexec);
        cyc("res.c4", S_ADDIWB,   o_addiwb);
        cyc("res.c5", S_FETCH,    o_fetch1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
